// File: rtl/branch_eval_pkg.sv
// Shared definitions for the branch evaluator: condition codes, FSM states
// and the condition-to-decision mapping.
package branch_eval_pkg;

  localparam logic [2:0] COND_BEQ    = 3'b000;
  localparam logic [2:0] COND_BNE    = 3'b001;
  localparam logic [2:0] COND_BLE    = 3'b010;
  localparam logic [2:0] COND_BGT    = 3'b011;
  localparam logic [2:0] COND_BLT    = 3'b100;
  localparam logic [2:0] COND_BGE    = 3'b101;
  localparam logic [2:0] COND_ALWAYS = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ALWAYS/NEVER need no operand comparison at all.
  function automatic logic cond_is_fixed(input logic [2:0] cond);
    return (cond == COND_ALWAYS) || (cond == COND_NEVER);
  endfunction

  function automatic logic eval_taken(input logic [2:0] cond,
                                      input logic       igual,
                                      input logic       maior,
                                      input logic       menor);
    logic t;
    case (cond)
      COND_BEQ:    t = igual;
      COND_BNE:    t = !igual;
      COND_BLE:    t = !maior;
      COND_BGT:    t = maior;
      COND_BLT:    t = menor;
      COND_BGE:    t = !menor;
      COND_ALWAYS: t = 1'b1;
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_eval_if.sv
// Request/response bundle between the control unit and the branch evaluator.
interface branch_eval_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [2:0]       cond;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             clr_cnt;
  logic             busy;
  logic             done;
  logic             taken;
  logic             igual;
  logic             maior;
  logic             menor;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output start, cond, is_signed, a, b, abort, clr_cnt,
    input  busy, done, taken, igual, maior, menor, branch_cnt, taken_cnt
  );

  modport slave (
    input  start, cond, is_signed, a, b, abort, clr_cnt,
    output busy, done, taken, igual, maior, menor, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_eval_chunk_cmp.sv
// Unsigned magnitude comparison of one operand chunk.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq,
  output logic             gt
);
  assign eq = (x == y);
  assign gt = (x > y);
endmodule

// File: rtl/branch_eval.sv
// Sequential branch-condition evaluator: compares A/B one chunk per cycle,
// MSB chunk first, stopping at the first differing chunk. Signed operands are
// converted to offset binary on capture so every chunk compares unsigned.
module branch_eval
  import branch_eval_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  branch_eval_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cond_q;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] x_chunk, y_chunk;
  logic             ch_eq, ch_gt;

  logic             accept, finish, flag_upd;
  logic [2:0]       cond_sel;
  logic             igual_n, maior_n, menor_n, taken_n;

  logic             busy_q, done_q, taken_q, igual_q, maior_q, menor_q;
  logic [CNT_W-1:0] bcnt_q, tcnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Flipping the sign bit maps two's complement onto unsigned order.
  function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return {v[WIDTH-1] ^ sgn, v[WIDTH-2:0]};
  endfunction

  assign x_chunk = a_q[idx*CHUNK +: CHUNK];
  assign y_chunk = b_q[idx*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
    .x  (x_chunk),
    .y  (y_chunk),
    .eq (ch_eq),
    .gt (ch_gt)
  );

  // A request dropped by a simultaneous abort never leaves IDLE.
  assign accept = (state == ST_IDLE) && bus.start && !bus.abort;

  // Next-state logic; finish marks the edge on which done rises.
  always_comb begin
    state_n  = state;
    finish   = 1'b0;
    flag_upd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cond_is_fixed(bus.cond)) begin
            state_n = ST_DONE;
            finish  = 1'b1;
          end else begin
            state_n = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
        end else if (!ch_eq || (idx == '0)) begin
          state_n  = ST_DONE;
          finish   = 1'b1;
          flag_upd = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Decision for the finishing evaluation; fixed conditions keep old flags.
  always_comb begin
    cond_sel = (state == ST_IDLE) ? bus.cond : cond_q;
    igual_n  = igual_q;
    maior_n  = maior_q;
    menor_n  = menor_q;
    if (flag_upd) begin
      igual_n = ch_eq;
      maior_n = ch_gt;
      menor_n = !ch_eq && !ch_gt;
    end
    taken_n = eval_taken(cond_sel, igual_n, maior_n, menor_n);
  end

  // Control state, registered outputs and saturating statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      igual_q <= 1'b0;
      maior_q <= 1'b0;
      menor_q <= 1'b0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != ST_IDLE);
      done_q <= finish;
      if (finish) begin
        taken_q <= taken_n;
        igual_q <= igual_n;
        maior_q <= maior_n;
        menor_q <= menor_n;
      end
      if (bus.clr_cnt) begin
        bcnt_q <= '0;
        tcnt_q <= '0;
      end else if (finish) begin
        bcnt_q <= sat_inc(bcnt_q);
        if (taken_n) tcnt_q <= sat_inc(tcnt_q);
      end
    end
  end

  // Operand capture and MSB-first chunk index; no reset needed on data.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= to_offset(bus.a, bus.is_signed);
      b_q    <= to_offset(bus.b, bus.is_signed);
      cond_q <= bus.cond;
      idx    <= IDX_W'(N - 1);
    end else if ((state == ST_CMP) && ch_eq && (idx != '0)) begin
      idx <= idx - IDX_W'(1);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.taken      = taken_q;
  assign bus.igual      = igual_q;
  assign bus.maior      = maior_q;
  assign bus.menor      = menor_q;
  assign bus.branch_cnt = bcnt_q;
  assign bus.taken_cnt  = tcnt_q;

endmodule

// File: tb/tb_branch_eval.sv
// Scoreboard bench for branch_eval: directed cases plus random operands,
// checked against a whole-operand reference model.
module tb_branch_eval;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int CNT_W = 4;
  localparam int N     = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_eval_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  branch_eval #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic taken;
    logic igual;
    logic maior;
    logic menor;
    int   bcnt;
    int   tcnt;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   ndone = 0;

  // reference model state
  logic m_igual = 1'b0, m_maior = 1'b0, m_menor = 1'b0;
  int   m_bcnt = 0, m_tcnt = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // cycles from accepted start to the done cycle
  function automatic int latency(input logic [2:0] cond, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    if (cond >= 3'd6) return 1;
    for (int i = N - 1; i >= 0; i--)
      if (((x >> (i * CHUNK)) & ((32'd1 << CHUNK) - 1)) != 0) return (N - i) + 1;
    return N + 1;
  endfunction

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      exp_t e;
      ndone++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("taken", bus.taken, e.taken);
        chk("igual", bus.igual, e.igual);
        chk("maior", bus.maior, e.maior);
        chk("menor", bus.menor, e.menor);
        chk("branch_cnt", bus.branch_cnt, e.bcnt);
        chk("taken_cnt", bus.taken_cnt, e.tcnt);
      end
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.cond = 3'd0; bus.is_signed = 1'b0;
    bus.a = '0; bus.b = '0; bus.abort = 1'b0; bus.clr_cnt = 1'b0;
  endtask

  // clr is only meaningful for ALWAYS/NEVER, where start and the done edge coincide
  task automatic issue(input logic [2:0] cond, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic clr, input logic extra_start);
    exp_t e;
    int   lat, d0;
    logic t;
    bit   seen;
    lat = latency(cond, a, b);
    if (cond < 3'd6) begin
      m_igual = (a == b);
      m_maior = sgn ? ($signed(a) > $signed(b)) : (a > b);
      m_menor = !m_igual && !m_maior;
    end
    case (cond)
      3'd0: t = m_igual;
      3'd1: t = !m_igual;
      3'd2: t = !m_maior;
      3'd3: t = m_maior;
      3'd4: t = m_menor;
      3'd5: t = !m_menor;
      3'd6: t = 1'b1;
      default: t = 1'b0;
    endcase
    if (clr) begin
      m_bcnt = 0; m_tcnt = 0;
    end else begin
      if (m_bcnt < CMAX) m_bcnt++;
      if (t && m_tcnt < CMAX) m_tcnt++;
    end
    @(posedge clk); #1;
    d0 = ndone;
    bus.start = 1'b1; bus.cond = cond; bus.is_signed = sgn;
    bus.a = a; bus.b = b; bus.clr_cnt = clr;
    e.taken = t; e.igual = m_igual; e.maior = m_maior; e.menor = m_menor;
    e.bcnt = m_bcnt; e.tcnt = m_tcnt; e.cyc = cyc + lat;
    q.push_back(e);
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    if (extra_start) begin
      bus.start = 1'b1; bus.cond = 3'd7; bus.a = ~a; bus.b = a;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < lat + 4 && !seen; i++) begin
      @(negedge clk); #1;
      if (ndone != d0) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles, expected latency %0d", lat + 4, lat);
      if (q.size() > 0) void'(q.pop_front());
    end else begin
      @(negedge clk);
      chk("busy_after_done", bus.busy, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_taken", bus.taken, 1'b0);
    chk("rst_flags", {bus.igual, bus.maior, bus.menor}, 3'b000);
    chk("rst_cnts", {bus.branch_cnt, bus.taken_cnt}, 8'h00);
    reset = 1'b1;

    // directed
    issue(3'd0, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0);
    issue(3'd3, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    issue(3'd3, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    issue(3'd1, 1'b0, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0);
    issue(3'd2, 1'b0, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0);
    issue(3'd0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b1);

    // abort in the second CMP cycle
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cond = 3'd0; bus.a = 32'hFFFF_0000; bus.b = 32'hFFFF_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_bcnt", bus.branch_cnt, m_bcnt);
    chk("abort_tcnt", bus.taken_cnt, m_tcnt);
    repeat (6) @(posedge clk);

    // abort together with start in IDLE drops the request
    #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.cond = 3'd6;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", bus.busy, 1'b0);
    repeat (3) @(posedge clk);

    // random operands, biased toward shared high chunks
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = $urandom;
        2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = {ra[31:16], 16'($urandom)};
      endcase
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, 1'b0, 1'b0);
    end

    // saturating counters
    issue(3'd6, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int n = 0; n < 17; n++) issue(3'd6, 1'b0, 32'($urandom), 32'($urandom), 1'b0, 1'b0);
    chk("sat_bcnt", bus.branch_cnt, CMAX);
    chk("sat_tcnt", bus.taken_cnt, CMAX);
    issue(3'd6, 1'b0, 32'd1, 32'd2, 1'b1, 1'b0);
    issue(3'd7, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0);

    // reset during the second CMP cycle of an equal-operand BEQ
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cond = 3'd0; bus.a = 32'h0BAD_BEEF; bus.b = 32'h0BAD_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_bcnt = 0; m_tcnt = 0; m_igual = 1'b0; m_maior = 1'b0; m_menor = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_taken", bus.taken, 1'b0);
    chk("mid_rst_flags", {bus.igual, bus.maior, bus.menor}, 3'b000);
    chk("mid_rst_cnts", {bus.branch_cnt, bus.taken_cnt}, 8'h00);
    repeat (6) @(posedge clk);
    issue(3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_eval.md
# branch_eval

Parametrised, sequential successor to the branch-condition logic of the multicycle processor. It compares two register operands chunk-by-chunk, MSB-first, with early termination, and evaluates a 3-bit branch condition in signed or unsigned mode. It returns a registered taken/not-taken decision to the control unit through a start/done handshake and keeps saturating branch statistics. It sits between the register-file outputs (A/B) and the control unit's PC-update logic.

## Interface
- WIDTH, 32: operand width; must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle; N = WIDTH/CHUNK chunks.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset is synchronous and active-low: reset==0 at a rising edge resets the block.
- start  in  1  request; accepted only in IDLE.
- cond  in  3  000 BEQ, 001 BNE, 010 BLE, 011 BGT, 100 BLT, 101 BGE, 110 ALWAYS, 111 NEVER.
- is_signed  in  1  two's-complement comparison when 1.
- a, b  in  WIDTH  operands; latched on an accepted start.
- abort  in  1  cancels an in-flight evaluation.
- clr_cnt  in  1  clears both counters.
- busy  out  1  high in CMP and DONE.
- done  out  1  one-cycle pulse; decision valid.
- taken  out  1  branch decision.
- igual, maior, menor  out  1  each  a==b, a>b, a<b for the last completed evaluation.
- branch_cnt, taken_cnt  out  CNT_W  completed evaluations / taken branches, saturating.

## Operation
- States: IDLE, CMP, DONE.
- IDLE + start:
  - Latch a, b, cond and is_signed, and set the chunk index to N-1 (top chunk).
  - cond 110/111 → DONE.
  - Any other cond → CMP.
- CMP, one chunk per cycle:
  - Chunks differ → record maior/menor and go to DONE.
  - Chunks equal and index 0 → record igual and go to DONE.
  - Otherwise decrement the index and stay in CMP.
- Signed mode: the MSB of both operands is inverted before comparing (offset binary), so all chunks then compare unsigned.
- DONE: done=1 for exactly one cycle; taken, flags and counters update on the same edge; then return to IDLE.
- Decision:
  - BEQ = igual
  - BNE = !igual
  - BLE = !maior
  - BGT = maior
  - BLT = menor
  - BGE = !menor
  - ALWAYS = 1
  - NEVER = 0
- ALWAYS/NEVER leave igual/maior/menor at their previous values.
- taken and the flags hold until the next done.
- Counters:
  - On done, branch_cnt increments and taken_cnt increments if taken.
  - Both saturate at all-ones; they never wrap.
- start while busy is ignored; no queueing.
- abort in CMP or DONE:
  - Next state is IDLE.
  - done is not asserted, and taken, flags and counters are unchanged.
  - abort with start in IDLE: abort wins, the request is dropped.
- clr_cnt with a counting done in the same cycle: clear wins, both counters become 0.

## Timing
- Reset values: state IDLE; busy, done, taken, igual, maior, menor, branch_cnt and taken_cnt are all 0.
- Reset mid-operation: returns to IDLE with no done pulse; reset overrides abort, clr_cnt and start.
- Start accepted in cycle 0:
  - ALWAYS/NEVER: done in cycle 1.
  - First differing chunk is the k-th examined (k = 1..N): done in cycle k+1.
  - Equal operands: done in cycle N+1 (5 for WIDTH=32, CHUNK=8).
- busy rises in cycle 1 and falls in the cycle after done.
- Next start is accepted in the cycle after done, so sustained throughput is one evaluation per latency+1 cycles.
- Every output is registered; none depends combinationally on any input.

## Structure
- branch_eval_pkg holds:
  - cond encodings as localparams (COND_BEQ..COND_NEVER);
  - the state encoding (ST_IDLE, ST_CMP, ST_DONE);
  - a function mapping {cond, igual, maior, menor} to taken.
- Sub-module chunk_cmp (combinational, parameter CHUNK): inputs x and y, outputs eq and gt. It is instantiated once and fed by a mux on the chunk index.
- The top-level holds the FSM, operand registers, index counter, flag/decision registers and counters.

## Test plan
- BEQ, a=5, b=5, unsigned → done in cycle 5; taken=1, igual=1; branch_cnt=1, taken_cnt=1.
- BGT, a=0x80000000, b=0x00000001:
  - signed → done in cycle 2, taken=0, menor=1;
  - unsigned → done in cycle 2, taken=1, maior=1.
- BNE, a=0x12345678, b=0x12345679 → done in cycle 5; taken=1, menor=1. BLE on the same operands → taken=1.
- Abort and ignored start:
  - BEQ, a=b, abort in cycle 2 → no done; busy=0 in cycle 3; counters unchanged.
  - start with new operands in cycle 1 → ignored.
- Counters, CNT_W=4:
  - 17 ALWAYS evaluations → branch_cnt=taken_cnt=15;
  - clr_cnt coinciding with the next done → both 0.
  - NEVER → done in cycle 1, taken=0.
- reset=0 in the second CMP cycle of an equal-operand BEQ → next cycle all outputs 0 and state IDLE; no done pulse.
